// File: rtl/plru_pkg.sv
// Shared definitions for the PLRU victim picker.
// Holds the controller state encoding used by plru_victim_picker.
package plru_pkg;

   // Controller states: accept request, pick victim, present result, pulse update
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      RESP = 2'd2,
      UPD  = 2'd3
   } plru_state_t;

endpackage : plru_pkg

// File: rtl/plru_victim_find.sv
// Combinational least-recently-used way finder.
// A way is the victim when it is eligible and is not more recent than any
// other eligible way. If the recency matrix is inconsistent and no way
// qualifies, the lowest-index eligible way is chosen instead.
module plru_victim_find #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]            eligible,
   input  logic [WIDTH-1:0][WIDTH-1:0] vv_matrix,
   output logic [WIDTH-1:0]            victim,
   output logic [IDX_W-1:0]            idx,
   output logic                        none
);

   logic             found_lru;
   logic             found_any;
   logic [WIDTH-1:0] others;

   // Scan for the least-recent eligible way, falling back to lowest eligible
   always_comb begin
      victim    = '0;
      idx       = '0;
      none      = ~|eligible;
      found_lru = 1'b0;
      found_any = 1'b0;
      others    = '0;
      for (int w = 0; w < WIDTH; w++) begin
         others = eligible & ~(WIDTH'(1) << w);
         if (!found_lru && eligible[w] && ((vv_matrix[w] & others) == '0)) begin
            found_lru = 1'b1;
            victim    = WIDTH'(1) << w;
            idx       = IDX_W'(w);
         end
      end
      if (!found_lru) begin
         for (int w = 0; w < WIDTH; w++) begin
            if (!found_any && eligible[w]) begin
               found_any = 1'b1;
               victim    = WIDTH'(1) << w;
               idx       = IDX_W'(w);
            end
         end
      end
   end

endmodule : plru_victim_find

// File: rtl/plru_victim_picker.sv
// PLRU victim picker: samples a candidate mask and recency matrix on a
// request handshake, returns the least-recent eligible way two cycles later,
// and after the response is consumed pulses an allocation update for one
// cycle so the recency owner can mark that way most recent.
// Optional feature: define PLRU_VICTIM_LOCK_EN to add a lock_mask input
// whose set bits exclude ways from victim selection.
module plru_victim_picker
   import plru_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [WIDTH-1:0]            req_cand,
   input  logic [WIDTH-1:0][WIDTH-1:0] vv_matrix,
`ifdef PLRU_VICTIM_LOCK_EN
   input  logic [WIDTH-1:0]            lock_mask,
`endif
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [WIDTH-1:0]            rsp_victim,
   output logic [IDX_W-1:0]            rsp_idx,
   output logic                        rsp_none,
   output logic                        alloc_en,
   output logic [WIDTH-1:0]            v_alloc
);

   plru_state_t               state_q;
   plru_state_t               state_d;
   logic [WIDTH-1:0]            cand_q;
   logic [WIDTH-1:0][WIDTH-1:0] matrix_q;
   logic [WIDTH-1:0]            eligible;
   logic [WIDTH-1:0]            find_victim;
   logic [IDX_W-1:0]            find_idx;
   logic                        find_none;
   logic [WIDTH-1:0]            victim_q;
   logic [IDX_W-1:0]            idx_q;
   logic                        none_q;
   logic                        req_fire;
   logic                        rsp_fire;

   assign req_fire = req_valid && req_ready;
   assign rsp_fire = rsp_valid && rsp_ready;

`ifdef PLRU_VICTIM_LOCK_EN
   logic [WIDTH-1:0] lock_q;

   // Capture the lock mask together with the request so later changes are ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= '0;
      end else if (req_fire) begin
         lock_q <= lock_mask;
      end
   end

   assign eligible = cand_q & ~lock_q;
`else
   assign eligible = cand_q;
`endif

   plru_victim_find #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_find (
      .eligible  (eligible),
      .vv_matrix (matrix_q),
      .victim    (find_victim),
      .idx       (find_idx),
      .none      (find_none)
   );

   // State register; reset discards any in-flight request, response or update
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/update outputs decoded from the current state
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alloc_en  = 1'b0;
      v_alloc   = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_fire) begin
               state_d = PICK;
            end
         end
         PICK: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_fire) begin
               state_d = none_q ? IDLE : UPD;
            end
         end
         UPD: begin
            alloc_en = 1'b1;
            v_alloc  = victim_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Snapshot the request inputs so the pick works on a stable copy
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q   <= '0;
         matrix_q <= '0;
      end else if (req_fire) begin
         cand_q   <= req_cand;
         matrix_q <= vv_matrix;
      end
   end

   // Register the finder result in PICK and hold it through RESP and UPD
   always_ff @(posedge clk) begin
      if (rst) begin
         victim_q <= '0;
         idx_q    <= '0;
         none_q   <= 1'b0;
      end else if (state_q == PICK) begin
         victim_q <= find_victim;
         idx_q    <= find_idx;
         none_q   <= find_none;
      end
   end

   assign rsp_victim = victim_q;
   assign rsp_idx    = idx_q;
   assign rsp_none   = none_q;

endmodule : plru_victim_picker

// File: tb/tb_plru_victim_picker.sv
// Directed testbench for plru_victim_picker (WIDTH=4).
// Reference recency order, most to least recent: 1, 3, 0, 2.
module tb_plru_victim_picker;

   localparam int WIDTH = 4;
   localparam int IDX_W = 2;

   logic                        clk;
   logic                        rst;
   logic                        req_valid;
   logic                        req_ready;
   logic [WIDTH-1:0]            req_cand;
   logic [WIDTH-1:0][WIDTH-1:0] vv_matrix;
`ifdef PLRU_VICTIM_LOCK_EN
   logic [WIDTH-1:0]            lock_mask;
`endif
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [WIDTH-1:0]            rsp_victim;
   logic [IDX_W-1:0]            rsp_idx;
   logic                        rsp_none;
   logic                        alloc_en;
   logic [WIDTH-1:0]            v_alloc;

   int compareCount;
   int failCount;

   // Rows: way i more recent than way j. 1>{3,0,2}, 3>{0,2}, 0>{2}, 2>{}
   logic [WIDTH-1:0][WIDTH-1:0] orderMatrix;
   // Ways 1 and 2 each claim to be more recent than the other
   logic [WIDTH-1:0][WIDTH-1:0] loopMatrix;

   plru_victim_picker #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cand   (req_cand),
      .vv_matrix  (vv_matrix),
`ifdef PLRU_VICTIM_LOCK_EN
      .lock_mask  (lock_mask),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_victim (rsp_victim),
      .rsp_idx    (rsp_idx),
      .rsp_none   (rsp_none),
      .alloc_en   (alloc_en),
      .v_alloc    (v_alloc)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one request, scramble inputs afterwards, and advance into RESP
   task automatic applyStimulus(input logic [WIDTH-1:0] cand,
                                input logic [WIDTH-1:0][WIDTH-1:0] matrix);
      req_valid = 1'b1;
      req_cand  = cand;
      vv_matrix = matrix;
      tick();
      req_valid = 1'b0;
      req_cand  = ~cand;
      vv_matrix = '1;
      checkOutput("pick_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("resp_req_ready", 32'(req_ready), 32'd0);
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;
      orderMatrix  = {4'b0101, 4'b0000, 4'b1101, 4'b0100};
      loopMatrix   = {4'b0000, 4'b0010, 4'b0100, 4'b0000};
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_cand     = '0;
      vv_matrix    = '0;
      rsp_ready    = 1'b0;
`ifdef PLRU_VICTIM_LOCK_EN
      lock_mask    = '0;
`endif

      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_victim", 32'(rsp_victim), 32'd0);
      checkOutput("rst_rsp_idx", 32'(rsp_idx), 32'd0);
      checkOutput("rst_rsp_none", 32'(rsp_none), 32'd0);
      checkOutput("rst_alloc_en", 32'(alloc_en), 32'd0);
      checkOutput("rst_v_alloc", 32'(v_alloc), 32'd0);

      $display("[TB] all ways eligible");
      applyStimulus(4'b1111, orderMatrix);
      checkOutput("all_victim", 32'(rsp_victim), 32'h4);
      checkOutput("all_idx", 32'(rsp_idx), 32'd2);
      checkOutput("all_none", 32'(rsp_none), 32'd0);
      checkOutput("all_alloc_pre", 32'(alloc_en), 32'd0);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("all_upd_alloc_en", 32'(alloc_en), 32'd1);
      checkOutput("all_upd_v_alloc", 32'(v_alloc), 32'h4);
      checkOutput("all_upd_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("all_upd_req_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      tick();
      checkOutput("all_idle_alloc_en", 32'(alloc_en), 32'd0);
      checkOutput("all_idle_v_alloc", 32'(v_alloc), 32'd0);
      checkOutput("all_idle_req_ready", 32'(req_ready), 32'd1);

      $display("[TB] way 2 excluded, response stalled");
      applyStimulus(4'b1011, orderMatrix);
      checkOutput("sub_victim", 32'(rsp_victim), 32'h1);
      checkOutput("sub_idx", 32'(rsp_idx), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("stall_victim", 32'(rsp_victim), 32'h1);
         checkOutput("stall_idx", 32'(rsp_idx), 32'd0);
         checkOutput("stall_none", 32'(rsp_none), 32'd0);
         checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
         checkOutput("stall_alloc_en", 32'(alloc_en), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("sub_upd_alloc_en", 32'(alloc_en), 32'd1);
      checkOutput("sub_upd_v_alloc", 32'(v_alloc), 32'h1);
      tick();
      checkOutput("sub_idle_req_ready", 32'(req_ready), 32'd1);

      $display("[TB] no candidates");
      applyStimulus(4'b0000, orderMatrix);
      checkOutput("none_flag", 32'(rsp_none), 32'd1);
      checkOutput("none_victim", 32'(rsp_victim), 32'd0);
      checkOutput("none_idx", 32'(rsp_idx), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("none_alloc_en", 32'(alloc_en), 32'd0);
      checkOutput("none_v_alloc", 32'(v_alloc), 32'd0);
      checkOutput("none_req_ready", 32'(req_ready), 32'd1);

      $display("[TB] single candidate way 3");
      applyStimulus(4'b1000, orderMatrix);
      checkOutput("one_victim", 32'(rsp_victim), 32'h8);
      checkOutput("one_idx", 32'(rsp_idx), 32'd3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("one_v_alloc", 32'(v_alloc), 32'h8);
      tick();

      $display("[TB] inconsistent matrix falls back to lowest eligible");
      applyStimulus(4'b0110, loopMatrix);
      checkOutput("loop_victim", 32'(rsp_victim), 32'h2);
      checkOutput("loop_idx", 32'(rsp_idx), 32'd1);
      checkOutput("loop_none", 32'(rsp_none), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("loop_v_alloc", 32'(v_alloc), 32'h2);
      tick();

`ifdef PLRU_VICTIM_LOCK_EN
      $display("[TB] way 2 locked");
      lock_mask = 4'b0100;
      applyStimulus(4'b1111, orderMatrix);
      lock_mask = '0;
      checkOutput("lock_victim", 32'(rsp_victim), 32'h1);
      checkOutput("lock_idx", 32'(rsp_idx), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("lock_v_alloc", 32'(v_alloc), 32'h1);
      tick();
`endif

      $display("[TB] reset while response pending");
      applyStimulus(4'b1111, orderMatrix);
      rst       = 1'b1;
      rsp_ready = 1'b1;
      tick();
      checkOutput("rstresp_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rstresp_alloc_en", 32'(alloc_en), 32'd0);
      checkOutput("rstresp_victim", 32'(rsp_victim), 32'd0);
      rst = 1'b0;
      tick();
      rsp_ready = 1'b0;
      checkOutput("rstresp_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rstresp_alloc_after", 32'(alloc_en), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule : tb_plru_victim_picker
